// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// AES_SEQ_WDOG_EN selects the watchdog timeout build.
package aes_seq_pkg;

    localparam int unsigned AES128_NR        = 10;
    localparam int unsigned ROUND_W          = 4;
    localparam int unsigned WDOG_CYC_DEFAULT = 15;
    localparam int unsigned STATE_W          = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_LOAD  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_ROUND = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_WAIT  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_OUT   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_DONE  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_ERR   = STATE_W'(6);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_ROUND = S_ROUND,
        ST_WAIT  = S_WAIT,
        ST_OUT   = S_OUT,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Host / round-engine / output-selector signal bundle for the round sequencer.
interface aes_round_sequencer_if;
    import aes_seq_pkg::*;

    logic               Start;
    logic               Mode;
    logic               RoundDone;
    logic               Ack;
    logic               Busy;
    logic               LoadEn;
    logic               RoundEn;
    logic [ROUND_W-1:0] RoundNum;
    logic               LastRound;
    logic               OutClr;
    logic               OutSel;
    logic               OutEn;
    logic               Done;
    logic               Err;

    modport master (
        output Start, Mode, RoundDone, Ack,
        input  Busy, LoadEn, RoundEn, RoundNum, LastRound, OutClr, OutSel, OutEn, Done, Err
    );

    modport slave (
        input  Start, Mode, RoundDone, Ack,
        output Busy, LoadEn, RoundEn, RoundNum, LastRound, OutClr, OutSel, OutEn, Done, Err
    );

endinterface

// File: rtl/aes_seq_wdog.sv
// WAIT-state cycle counter; expired_c flags the LIMIT-th consecutive WAIT cycle.
module aes_seq_wdog #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at CNT_MAX; the sequencer leaves WAIT before it matters.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES-128 datapath: load, NR round pulses, publish, handshake.
// Define AES_SEQ_WDOG_EN to add the per-round WAIT watchdog and the ERR state.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned NR = AES128_NR
`ifdef AES_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC = WDOG_CYC_DEFAULT
`endif
) (
    input logic                  Clk,
    input logic                  Rst,
    aes_round_sequencer_if.slave bus
);
    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);

    seq_state_e         state_q, state_d;
    logic               mode_q, mode_d;
    logic [ROUND_W-1:0] round_num_q, round_num_d;
    logic               busy_q, busy_d;
    logic               load_en_q, load_en_d;
    logic               round_en_q, round_en_d;
    logic               last_round_q, last_round_d;
    logic               out_en_q, out_en_d;
    logic               done_q, done_d;

`ifdef AES_SEQ_WDOG_EN
    logic err_q, err_d;
    logic wdog_clr_c, wdog_en_c, wdog_exp_c;

    aes_seq_wdog #(
        .LIMIT(WDOG_CYC)
    ) u_wdog (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (wdog_clr_c),
        .enable   (wdog_en_c),
        .expired_c(wdog_exp_c)
    );
`endif

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        round_num_d = round_num_q;
`ifdef AES_SEQ_WDOG_EN
        wdog_clr_c  = 1'b0;
        wdog_en_c   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    mode_d      = bus.Mode;
                    round_num_d = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                round_num_d = ROUND_W'(1);
                state_d     = ST_ROUND;
            end
            ST_ROUND: begin
`ifdef AES_SEQ_WDOG_EN
                wdog_clr_c = 1'b1;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef AES_SEQ_WDOG_EN
                wdog_en_c = 1'b1;
`endif
                // RoundDone takes priority over a coincident timeout.
                if (bus.RoundDone) begin
                    if (round_num_q == LAST_RND) begin
                        state_d = ST_OUT;
                    end else begin
                        round_num_d = round_num_q + ROUND_W'(1);
                        state_d     = ST_ROUND;
                    end
                end
`ifdef AES_SEQ_WDOG_EN
                else if (wdog_exp_c) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_OUT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.Ack) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AES_SEQ_WDOG_EN
            ST_ERR: begin
                if (bus.Ack) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        load_en_d    = (state_d == ST_LOAD);
        round_en_d   = (state_d == ST_ROUND);
        last_round_d = (round_num_d == LAST_RND);
        out_en_d     = (state_d == ST_OUT);
        done_d       = (state_d == ST_DONE);
`ifdef AES_SEQ_WDOG_EN
        err_d        = (state_d == ST_ERR);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            round_num_q  <= '0;
            busy_q       <= 1'b0;
            load_en_q    <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            out_en_q     <= 1'b0;
            done_q       <= 1'b0;
`ifdef AES_SEQ_WDOG_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            round_num_q  <= round_num_d;
            busy_q       <= busy_d;
            load_en_q    <= load_en_d;
            round_en_q   <= round_en_d;
            last_round_q <= last_round_d;
            out_en_q     <= out_en_d;
            done_q       <= done_d;
`ifdef AES_SEQ_WDOG_EN
            err_q        <= err_d;
`endif
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.LoadEn    = load_en_q;
    assign bus.OutClr    = load_en_q;
    assign bus.RoundEn   = round_en_q;
    assign bus.RoundNum  = round_num_q;
    assign bus.LastRound = last_round_q;
    assign bus.OutSel    = mode_q;
    assign bus.OutEn     = out_en_q;
    assign bus.Done      = done_q;
`ifdef AES_SEQ_WDOG_EN
    assign bus.Err       = err_q;
`else
    assign bus.Err       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: timeline model of each request, directed table plus random runs.
// With AES_SEQ_WDOG_EN defined the watchdog timeout sequence is also exercised.
module tb_aes_round_sequencer;

    localparam int NRT  = 10;
    localparam int WDOG = 15;
    localparam int BIG  = 1000000;

    typedef struct {
        int mode;
        int delay;
        int ack_wait;
        bit noise;
        bit start_at_ack;
        int exp_out;
        int exp_done;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst;
    aes_round_sequencer_if bus();

    aes_round_sequencer dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int rn_hold = 0;
    bit sel_hold = 1'b0;
    int dly[NRT+1];
    vec_t vq[$];
    int o_off, d_off;

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic check_outs(input int k, input bit busy, input bit load, input bit ren, input int rn,
                              input bit oen, input bit osel, input bit done, input bit err);
        chk("busy",       k, int'(bus.Busy),      int'(busy));
        chk("load_en",    k, int'(bus.LoadEn),    int'(load));
        chk("out_clr",    k, int'(bus.OutClr),    int'(load));
        chk("round_en",   k, int'(bus.RoundEn),   int'(ren));
        chk("round_num",  k, int'(bus.RoundNum),  rn);
        chk("last_round", k, int'(bus.LastRound), int'(rn == NRT));
        chk("out_en",     k, int'(bus.OutEn),     int'(oen));
        chk("out_sel",    k, int'(bus.OutSel),    int'(osel));
        chk("done",       k, int'(bus.Done),      int'(done));
        chk("err",        k, int'(bus.Err),       int'(err));
    endtask

    // Idle cycles: nothing but ignored Ack/RoundDone noise is applied.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            bus.Start     = 1'b0;
            bus.Mode      = 1'($urandom_range(0, 1));
            bus.RoundDone = 1'($urandom_range(0, 1));
            bus.Ack       = 1'($urandom_range(0, 1));
            Rst           = 1'b0;
            @(negedge Clk);
            check_outs(k, 1'b0, 1'b0, 1'b0, rn_hold, 1'b0, sel_hold, 1'b0, 1'b0);
        end
    endtask

    // One request. Cycle 0 carries Start; every later cycle is predicted from a schedule of
    // round start cycles built from dly[] (extra WAIT cycles per round).
    task automatic run_txn(input int m, input int ack_wait, input int abort_rnd, input int wd_rnd,
                           input bit noise, input bit start_at_ack,
                           output int out_off, output int done_off);
        int r[NRT+2];
        int wend[NRT+1];
        int out_c, done_c, err_c, ack_c, abort_c, last_c, rn;
        bit in_wait, rd, st, ak, ren;
        err_c   = BIG;
        r[0]    = 0;
        wend[0] = 0;
        r[1]    = 2;
        for (int i = 1; i <= NRT; i++) begin
            if (r[i] >= BIG) begin
                wend[i] = BIG;
                r[i+1]  = BIG;
            end else if (wd_rnd == i) begin
                err_c   = r[i] + 1 + WDOG;
                wend[i] = err_c - 1;
                r[i+1]  = BIG;
            end else begin
                wend[i] = r[i] + 1 + dly[i];
                r[i+1]  = wend[i] + 1;
            end
        end
        out_c   = r[NRT+1];
        done_c  = (out_c >= BIG) ? BIG : out_c + 1;
        ack_c   = ((wd_rnd > 0) ? err_c : done_c) + ack_wait;
        abort_c = (abort_rnd > 0) ? r[abort_rnd] + 1 : BIG;
        last_c  = (abort_rnd > 0) ? abort_c : ack_c;
        out_off  = -1;
        done_off = -1;
        for (int k = 0; k <= last_c; k++) begin
            @(posedge Clk); #1;
            in_wait = 1'b0;
            rd      = 1'b0;
            ren     = 1'b0;
            for (int i = 1; i <= NRT; i++) begin
                if (k > r[i] && k <= wend[i]) in_wait = 1'b1;
                if (k == wend[i] && wd_rnd != i) rd = 1'b1;
                if (k == r[i]) ren = 1'b1;
            end
            if (noise && !in_wait && $urandom_range(0, 2) == 0) rd = 1'b1;
            st = (k == 0) || (start_at_ack && k == ack_c) ||
                 (noise && k > 0 && k <= ack_c && (k == r[5] + 1 || $urandom_range(0, 3) == 0));
            ak = (k == ack_c) ||
                 (noise && k < ((wd_rnd > 0) ? err_c : done_c) && $urandom_range(0, 3) == 0);
            bus.Start     = st;
            bus.Mode      = (k == 0) ? m[0] : 1'($urandom_range(0, 1));
            bus.RoundDone = rd;
            bus.Ack       = ak;
            Rst           = (k == abort_c);
            @(negedge Clk);
            if (k == 0) begin
                rn = rn_hold;
            end else begin
                rn = 0;
                for (int i = 1; i <= NRT; i++) if (k >= r[i]) rn = i;
            end
            check_outs(k, (k >= 1 && k <= ack_c), (k == 1), ren, rn, (k == out_c),
                       (k == 0) ? sel_hold : m[0], (k >= done_c && k <= ack_c),
                       (k >= err_c && k <= ack_c));
            if (bus.OutEn && out_off < 0) out_off = k;
            if (bus.Done && done_off < 0) done_off = k;
        end
        if (abort_rnd > 0) begin
            @(posedge Clk); #1;
            Rst           = 1'b0;
            bus.Start     = 1'b0;
            bus.RoundDone = 1'b0;
            bus.Ack       = 1'b0;
            @(negedge Clk);
            check_outs(abort_c + 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            rn_hold  = 0;
            sel_hold = 1'b0;
        end else begin
            rn_hold  = (wd_rnd > 0) ? wd_rnd : NRT;
            sel_hold = m[0];
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.Mode      = 1'b0;
        bus.RoundDone = 1'b0;
        bus.Ack       = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_outs(-1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        vq.push_back('{1,  0, 0, 1'b0, 1'b0,  22,  23});
        vq.push_back('{0,  3, 2, 1'b0, 1'b0,  52,  53});
        vq.push_back('{1,  1, 1, 1'b1, 1'b0,  32,  33});
        vq.push_back('{0,  0, 0, 1'b0, 1'b1,  22,  23});
        vq.push_back('{1, 14, 0, 1'b1, 1'b0, 162, 163});
`ifndef AES_SEQ_WDOG_EN
        vq.push_back('{0, 20, 1, 1'b0, 1'b0, 222, 223});
`endif
        foreach (vq[v]) begin
            for (int i = 1; i <= NRT; i++) dly[i] = vq[v].delay;
            run_txn(vq[v].mode, vq[v].ack_wait, 0, 0, vq[v].noise, vq[v].start_at_ack, o_off, d_off);
            chk("vec_out_cycle", v, o_off, vq[v].exp_out);
            chk("vec_done_cycle", v, d_off, vq[v].exp_done);
        end

        // Reset in WAIT of round 7, then quiet period, then a clean full request.
        for (int i = 1; i <= NRT; i++) dly[i] = 1;
        run_txn(1, 0, 7, 0, 1'b0, 1'b0, o_off, d_off);
        chk("abort_no_out", 0, o_off, -1);
        idle_cycles(30);
        for (int i = 1; i <= NRT; i++) dly[i] = 0;
        run_txn(1, 0, 0, 0, 1'b0, 1'b0, o_off, d_off);
        chk("post_abort_out_cycle", 0, o_off, 22);

`ifdef AES_SEQ_WDOG_EN
        // RoundDone withheld in round 3: timeout to ERR, never OutEn.
        for (int i = 1; i <= NRT; i++) dly[i] = 0;
        run_txn(1, 2, 0, 3, 1'b1, 1'b0, o_off, d_off);
        chk("wdog_no_out", 0, o_off, -1);
        chk("wdog_no_done", 0, d_off, -1);
        run_txn(0, 0, 0, 0, 1'b0, 1'b0, o_off, d_off);
        chk("post_err_out_cycle", 0, o_off, 22);
`endif

        for (int n = 0; n < 20; n++) begin
            for (int i = 1; i <= NRT; i++) dly[i] = $urandom_range(0, 4);
            run_txn($urandom_range(0, 1), $urandom_range(0, 3), 0, 0, 1'b1, 1'b0, o_off, d_off);
        end

        idle_cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
